// File: rtl/main_control_fsm_pkg.sv
// Shared definitions for the multicycle main control unit.
// Holds the RV32I-subset opcode constants, the alu_cmd class codes (shared
// with the ALU control block), the latched instruction class encodings, the
// FSM state encodings and small helpers that map a class to its ALU operands.
package main_control_fsm_pkg;

    // Supported major opcodes (instr[6:0])
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // alu_cmd class codes consumed by ALU control together with funct3/funct7
    localparam logic [3:0] ALU_CMD_RTYPE = 4'b0000;
    localparam logic [3:0] ALU_CMD_ITYPE = 4'b0001;
    localparam logic [3:0] ALU_CMD_STYPE = 4'b0010;
    localparam logic [3:0] ALU_CMD_BTYPE = 4'b0011;

    // Instruction class latched in DECODE
    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_I      = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    // ALU class code used while an instruction of class cls owns the ALU
    function automatic logic [3:0] class_alu_cmd(input logic [2:0] cls);
        logic [3:0] cmd;
        case (cls)
            CLS_R:      cmd = ALU_CMD_RTYPE;
            CLS_STORE:  cmd = ALU_CMD_STYPE;
            CLS_BRANCH: cmd = ALU_CMD_BTYPE;
            default:    cmd = ALU_CMD_ITYPE;
        endcase
        return cmd;
    endfunction

    // Operand B is the immediate for I-ALU, loads and stores
    function automatic logic class_uses_imm(input logic [2:0] cls);
        return (cls == CLS_I) || (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/main_control_fsm_opcode_class_decode.sv
// Combinational opcode classifier used by the DECODE step.
// Ports:
//   opcode_i  instr[6:0]
//   cls_o     instruction class (CLS_*), CLS_I when not valid
//   valid_o   1 when the opcode belongs to the supported subset
module opcode_class_decode
    import main_control_fsm_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] cls_o,
    output logic       valid_o
);

    always_comb begin
        cls_o   = CLS_I;
        valid_o = 1'b1;
        case (opcode_i)
            OP_RTYPE:  cls_o = CLS_R;
            OP_ITYPE:  cls_o = CLS_I;
            OP_LOAD:   cls_o = CLS_LOAD;
            OP_STORE:  cls_o = CLS_STORE;
            OP_BRANCH: cls_o = CLS_BRANCH;
            default:   valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control unit for the RV32I-subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath enables, memory requests and the alu_cmd class code.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   opcode                instr[6:0] from the instruction register
//   zero                  ALU zero flag, used for beq in EXEC
//   imem_ready/dmem_ready single-cycle completion pulses from memories
//   imem_req, ir_load     instruction fetch request / IR load enable
//   dmem_req, dmem_we     data memory request / write qualifier
//   alu_cmd, alu_src      ALU class code / immediate operand select
//   reg_write, mem_to_reg register write enable / writeback source
//   pc_load, pc_src       PC update enable / PC+imm select
//   illegal               sticky unsupported-opcode flag
//   instret               retired-instruction counter
module main_control_fsm
    import main_control_fsm_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [CMD_W-1:0] alu_cmd,
    output logic             alu_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             pc_load,
    output logic             pc_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    logic [2:0]       state_q, state_d;
    logic [2:0]       cls_q, cls_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q;

    logic [2:0]       dec_cls;
    logic             dec_valid;

    opcode_class_decode u_decode (
        .opcode_i (opcode),
        .cls_o    (dec_cls),
        .valid_o  (dec_valid)
    );

    // ir_load and the store retire pulse follow the ready inputs directly so
    // the single-cycle ready pulse is consumed in the cycle it arrives.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        illegal_d  = illegal_q;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_cmd    = CMD_W'(ALU_CMD_ITYPE);
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_load    = 1'b0;
        pc_src     = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_valid) begin
                    cls_d   = dec_cls;
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_EXEC: begin
                alu_cmd = CMD_W'(class_alu_cmd(cls_q));
                alu_src = class_uses_imm(cls_q);
                case (cls_q)
                    CLS_BRANCH: begin
                        pc_load = 1'b1;
                        pc_src  = zero;
                        state_d = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                alu_cmd  = CMD_W'(class_alu_cmd(cls_q));
                alu_src  = class_uses_imm(cls_q);
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CLS_STORE);
                if (dmem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        pc_load = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                alu_cmd    = CMD_W'(class_alu_cmd(cls_q));
                alu_src    = class_uses_imm(cls_q);
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == CLS_LOAD);
                pc_load    = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_I;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            if (pc_load) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_main_control_fsm.sv
module tb_main_control_fsm;
    import main_control_fsm_pkg::*;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  alu_cmd;
    logic        alu_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic        pc_load;
    logic        pc_src;
    logic        illegal;
    logic [31:0] instret;

    main_control_fsm #(.CNT_W(32), .CMD_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_load    (ir_load),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .alu_cmd    (alu_cmd),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .pc_load    (pc_load),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected signature of one retire cycle (pc_load = 1)
    typedef struct packed {
        logic [3:0]  cmd;
        logic        src;
        logic        rw;
        logic        m2r;
        logic        psrc;
        logic        we;
        logic [31:0] ret;
        logic [31:0] lat;
    } exp_t;

    exp_t sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned mon_cyc = 0;
    logic        mon_prev_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] cmd, input logic src, input logic rw,
                                input logic m2r, input logic psrc, input logic we,
                                input logic [31:0] ret, input logic [31:0] lat);
        exp_t e;
        e.cmd = cmd; e.src = src; e.rw = rw; e.m2r = m2r;
        e.psrc = psrc; e.we = we; e.ret = ret; e.lat = lat;
        return e;
    endfunction

    // Monitor: latency counted from FETCH entry (imem_req rising), scoreboard
    // popped on every retire cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_cyc      = 0;
                mon_prev_req = 1'b0;
            end else begin
                if (imem_req && !mon_prev_req) mon_cyc = 1;
                else if (mon_cyc != 0)         mon_cyc++;
                mon_prev_req = imem_req;
                if (pc_load) begin
                    if (sb.size() == 0) begin
                        check("unexpected_retire", 32'(pc_load), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("ret_alu_cmd",    32'(alu_cmd),    32'(e.cmd));
                        check("ret_alu_src",    32'(alu_src),    32'(e.src));
                        check("ret_reg_write",  32'(reg_write),  32'(e.rw));
                        check("ret_mem_to_reg", 32'(mem_to_reg), 32'(e.m2r));
                        check("ret_pc_src",     32'(pc_src),     32'(e.psrc));
                        check("ret_dmem_we",    32'(dmem_we),    32'(e.we));
                        check("ret_instret",    instret,         e.ret);
                        check("ret_latency",    32'(mon_cyc),    e.lat);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_imem_req();
        int n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        check("imem_req_seen", 32'(imem_req), 32'd1);
    endtask

    // Leaves the FSM in DECODE (posedge+1) with opcode still applied.
    task automatic fetch(input logic [6:0] op, input logic z, input int fw);
        wait_imem_req();
        opcode = op;
        zero   = z;
        repeat (fw) begin
            check("fetch_hold", 32'(imem_req), 32'd1);
            step();
        end
        imem_ready = 1'b1;
        #1;
        check("ir_load", 32'(ir_load), 32'd1);
        step();
        imem_ready = 1'b0;
        check("ir_load_clear", 32'(ir_load), 32'd0);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic z, input int fw,
                             input bit is_mem, input int mw, input exp_t e);
        int n_req = 0;
        int n = 0;
        sb.push_back(e);
        fetch(op, z, fw);
        step();
        if (is_mem) begin
            while (!dmem_req && n < 50) begin
                step();
                n++;
            end
            for (int k = 0; k < mw; k++) begin
                if (dmem_req) n_req++;
                check("mem_we_wait", 32'(dmem_we), 32'(e.we));
                step();
            end
            dmem_ready = 1'b1;
            if (dmem_req) n_req++;
            step();
            dmem_ready = 1'b0;
            check("dmem_req_cycles", 32'(n_req), 32'(mw + 1));
            check("dmem_req_dropped", 32'(dmem_req), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; opcode = OP_ITYPE; zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        step(); step();
        check("rst_imem_req",  32'(imem_req),  32'd0);
        check("rst_alu_cmd",   32'(alu_cmd),   32'd1);
        check("rst_illegal",   32'(illegal),   32'd0);
        check("rst_instret",   instret,        32'd0);
        check("rst_pc_load",   32'(pc_load),   32'd0);
        check("rst_reg_write", 32'(reg_write), 32'd0);
        rst = 1'b0;

        //                 op         z     fw mem mw       cmd    src rw m2r ps we ret lat
        run_instr(OP_RTYPE,  1'b0, 0, 0, 0, mk(4'h0, 0, 1, 0, 0, 0, 0, 4));
        run_instr(OP_LOAD,   1'b0, 0, 1, 3, mk(4'h1, 1, 1, 1, 0, 0, 1, 8));
        run_instr(OP_STORE,  1'b0, 0, 1, 0, mk(4'h2, 1, 0, 0, 0, 1, 2, 4));
        run_instr(OP_BRANCH, 1'b1, 0, 0, 0, mk(4'h3, 0, 0, 0, 1, 0, 3, 3));
        run_instr(OP_BRANCH, 1'b0, 0, 0, 0, mk(4'h3, 0, 0, 0, 0, 0, 4, 3));
        run_instr(OP_ITYPE,  1'b0, 2, 0, 0, mk(4'h1, 1, 1, 0, 0, 0, 5, 6));
        wait_imem_req();
        check("instret_after_six", instret, 32'd6);

        // Reset in the middle of a load's MEM phase
        fetch(OP_LOAD, 1'b0, 0);
        step();
        step();
        check("mem_req_before_rst", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        step();
        check("rst_mem_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_mem_instret",  instret,        32'd0);
        check("rst_mem_imem_req", 32'(imem_req), 32'd0);
        check("rst_mem_alu_cmd",  32'(alu_cmd),  32'd1);
        rst = 1'b0;
        step();
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        check("stray_dmem_ready", 32'(dmem_req), 32'd0);
        check("stray_still_fetch", 32'(imem_req), 32'd1);
        // FETCH entered one cycle before this fetch starts
        run_instr(OP_RTYPE, 1'b0, 0, 0, 0, mk(4'h0, 0, 1, 0, 0, 0, 0, 5));

        // Unsupported opcode traps until reset
        fetch(7'b1111111, 1'b0, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            check("trap_illegal",  32'(illegal),  32'd1);
            check("trap_imem_req", 32'(imem_req), 32'd0);
            check("trap_dmem_req", 32'(dmem_req), 32'd0);
            step();
        end
        check("trap_alu_cmd", 32'(alu_cmd), 32'd1);
        rst = 1'b1;
        step();
        check("trap_rst_illegal",  32'(illegal),  32'd0);
        check("trap_rst_imem_req", 32'(imem_req), 32'd0);
        rst = 1'b0;
        step();
        check("post_idle_fetch", 32'(imem_req), 32'd1);

        step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
